pipelined_add_sub: RTL and testbench

- Parametrised, pipelined N-bit adder/subtractor. It is the next generation of the team's single-bit structural full-adder cell.
- Splits a WIDTH-bit add or subtract into STAGES equal ripple segments. The carry is registered between segments.
- Uses a valid/ready handshake on both sides, so it drops into ALU datapaths that need high clock rate and back-pressure.

---
 rtl/pipelined_add_sub.sv | 176 +++++++++++++++++
 tb/tb_pipelined_add_sub.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_add_sub.sv
// ---------------------------------------------------------------------------
// pipelined_add_sub
//
// Purpose:
//   WIDTH-bit adder/subtractor split into STAGES equal ripple segments. Each
//   stage adds one SEG-bit slice and registers its carry for the next slice.
//   The operand bits that are not yet consumed ride along in skew registers.
//   The finished low result bits ride along in deskew registers. This way
//   every bit of a beat leaves the pipe in the same cycle. There is a
//   valid/ready handshake on both sides and a global stall: when the output
//   is full and not taken, every stage holds.
//
// Parameters:
//   WIDTH   operand/result width (default 32)
//   STAGES  number of pipeline segments (default 4); must divide WIDTH
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   operand beat valid
//   in_ready   out  beat accepted this cycle when in_valid is also high
//   a, b       in   operands [WIDTH-1:0]
//   sub        in   0: a+b, 1: a-b
//   out_valid  out  result valid
//   out_ready  in   downstream takes the result
//   sum        out  result [WIDTH-1:0]
//   c_out      out  carry out of the MSB (subtract: 1 = no borrow)
//   ovf        out  two's-complement signed overflow
//
// Build option:
//   PIPELINED_ADD_SUB_SATURATE_EN  when defined, sum is clamped to the most
//   positive or most negative value on overflow. The clamp direction comes
//   from the sign of a. c_out and ovf still report the raw result.
// ---------------------------------------------------------------------------
module pipelined_add_sub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int SEG = WIDTH / STAGES;

   // Reject a segment split that does not tile the word exactly.
   if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
      $error("pipelined_add_sub: WIDTH must be a multiple of STAGES");
   end

   logic advance;

   // Global stall: the whole pipe moves only when the output slot is empty
   // or is being drained this cycle. Bubbles are kept in place, not collapsed.
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      // Operand bits still to be added when this stage starts. The LSB of
      // the remaining operand is bit k*SEG of the original operand.
      localparam int IW = WIDTH - k * SEG;

      logic [IW-1:0]        in_a;
      logic [IW-1:0]        in_b;
      logic                 in_cy;
      logic                 in_v;
      logic [SEG:0]         seg_sum;
      logic [(k+1)*SEG-1:0] res_nxt;

      // Stage 0 takes its inputs straight from the ports. It inverts b and
      // injects sub as the carry-in, which turns a-b into a+~b+1. Later
      // stages need no sub flag: the inverted operand bits and the carry
      // already encode the operation of the beat.
      if (k == 0) begin : g_src_in
         assign in_a    = a;
         assign in_b    = sub ? ~b : b;
         assign in_cy   = sub;
         assign in_v    = in_valid;
         assign res_nxt = seg_sum[SEG-1:0];
      end else begin : g_src_prev
         assign in_a    = g_stage[k-1].g_pass.a_q;
         assign in_b    = g_stage[k-1].g_pass.b_q;
         assign in_cy   = g_stage[k-1].g_pass.cy_q;
         assign in_v    = g_stage[k-1].g_pass.vld_q;
         assign res_nxt = {seg_sum[SEG-1:0], g_stage[k-1].g_pass.res_q};
      end

      // Ripple add of this stage's slice; the top bit is the slice carry-out.
      assign seg_sum = {1'b0, in_a[SEG-1:0]} + {1'b0, in_b[SEG-1:0]}
                     + {{SEG{1'b0}}, in_cy};

      if (k < STAGES - 1) begin : g_pass
         logic                 vld_q;
         logic [IW-SEG-1:0]    a_q;
         logic [IW-SEG-1:0]    b_q;
         logic                 cy_q;
         logic [(k+1)*SEG-1:0] res_q;

         // Intermediate stage register. It keeps the unconsumed upper
         // operand bits (skew), the finished low result bits (deskew) and
         // the slice carry. Reset clears everything, so beats in flight are
         // thrown away.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               vld_q <= 1'b0;
               a_q   <= '0;
               b_q   <= '0;
               cy_q  <= 1'b0;
               res_q <= '0;
            end else if (advance) begin
               vld_q <= in_v;
               a_q   <= in_a[IW-1:SEG];
               b_q   <= in_b[IW-1:SEG];
               cy_q  <= seg_sum[SEG];
               res_q <= res_nxt;
            end
         end
      end else begin : g_last
         logic             vld_q;
         logic [WIDTH-1:0] res_q;
         logic             cy_q;
         logic             ovf_q;
         logic             ovf_raw;
         logic [WIDTH-1:0] res_fin;

         // The carry into the MSB is a^b^sum at that bit. Signed overflow
         // is that carry XOR the carry out of the MSB.
         assign ovf_raw = in_a[SEG-1] ^ in_b[SEG-1] ^ seg_sum[SEG-1] ^ seg_sum[SEG];

`ifdef PIPELINED_ADD_SUB_SATURATE_EN
         // Clamp on overflow. Overflow can only happen when a and b_eff share
         // a sign, so the sign of a tells which rail was crossed.
         always_comb begin
            res_fin = res_nxt;
            if (ovf_raw) begin
               res_fin = in_a[SEG-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
            end
         end
`else
         assign res_fin = res_nxt;
`endif

         // Output register. It holds its value while the consumer stalls,
         // because advance is low whenever out_valid=1 and out_ready=0.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               vld_q <= 1'b0;
               res_q <= '0;
               cy_q  <= 1'b0;
               ovf_q <= 1'b0;
            end else if (advance) begin
               vld_q <= in_v;
               res_q <= res_fin;
               cy_q  <= seg_sum[SEG];
               ovf_q <= ovf_raw;
            end
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].g_last.vld_q;
   assign sum       = g_stage[STAGES-1].g_last.res_q;
   assign c_out     = g_stage[STAGES-1].g_last.cy_q;
   assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// ---------------------------------------------------------------------------
// tb_pipelined_add_sub
//
// Purpose:
//   Self-checking bench for pipelined_add_sub with WIDTH=8, STAGES=4.
//   Expected results come from a reference model built on plain integer
//   arithmetic. The model fills a queue in acceptance order, and every
//   output handshake pops that queue and compares against it.
//   The bench covers:
//     - reset values
//     - latency
//     - directed corner sums
//     - stall with back-pressure
//     - bubble pattern
//     - random traffic
//     - reset while beats are in flight
//   If PIPELINED_ADD_SUB_SATURATE_EN is defined, the same macro switches the
//   model to clamped results.
// ---------------------------------------------------------------------------
module tb_pipelined_add_sub;

   localparam int WIDTH  = 8;
   localparam int STAGES = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             c_out;
   logic             ovf;

   int errors = 0;
   int checks = 0;

   // Expected {ovf, c_out, sum} for each accepted beat, oldest first.
   logic [9:0] expq [$];

   pipelined_add_sub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .c_out     (c_out),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   // Safety net so the run always ends even if a loop bound is broken.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model: signed and unsigned integer arithmetic on whole values.
   function automatic logic [9:0] refModel(logic [7:0] va, logic [7:0] vb, logic vs);
      int sa, sb, sr, ua, ub;
      logic [7:0] s8;
      logic c, o;
      sa = int'($signed(va));
      sb = int'($signed(vb));
      ua = int'(va);
      ub = int'(vb);
      sr = vs ? sa - sb : sa + sb;
      c  = vs ? (ua >= ub) : ((ua + ub) > 255);
      o  = (sr > 127) || (sr < -128);
      s8 = sr[7:0];
`ifdef PIPELINED_ADD_SUB_SATURATE_EN
      if (o) s8 = (sr > 127) ? 8'h7F : 8'h80;
`endif
      return {o, c, s8};
   endfunction

   // One comparison, counted and asserted.
   task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(logic v, logic [7:0] va, logic [7:0] vb, logic vs);
      in_valid = v;
      a        = va;
      b        = vb;
      sub      = vs;
   endtask

   // Advance one clock. Handshakes are sampled on the falling edge. The
   // scoreboard is updated there, and the task returns 1 time unit after
   // the rising edge.
   task automatic tick();
      logic acc, dep;
      logic [9:0] e;
      @(negedge clk);
      acc = rst_n && in_valid && in_ready;
      dep = rst_n && out_valid && out_ready;
      if (dep) begin
         checkOutput("sb_pending", 32'(expq.size() != 0), 32'd1);
         if (expq.size() != 0) begin
            e = expq.pop_front();
            checkOutput("sb_sum", 32'(sum), 32'(e[7:0]));
            checkOutput("sb_cout", 32'(c_out), 32'(e[8]));
            checkOutput("sb_ovf", 32'(ovf), 32'(e[9]));
         end
      end
      if (!rst_n) expq.delete();
      else if (acc) expq.push_back(refModel(a, b, sub));
      @(posedge clk);
      #1;
   endtask

   // Send one beat into an empty pipe and check its latency and fields.
   task automatic runSingle(string tag, logic [7:0] va, logic [7:0] vb, logic vs,
                            logic [7:0] es, logic ec, logic eo);
      int n;
      applyStimulus(1'b1, va, vb, vs);
      tick();
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
      n = 1;
      while (out_valid !== 1'b1 && n < 12) begin
         tick();
         n++;
      end
      checkOutput({tag, "_lat"}, 32'(n), 32'(STAGES));
      checkOutput({tag, "_sum"}, 32'(sum), 32'(es));
      checkOutput({tag, "_cout"}, 32'(c_out), 32'(ec));
      checkOutput({tag, "_ovf"}, 32'(ovf), 32'(eo));
      tick();
   endtask

   initial begin
      logic pat [12];
      logic ov  [12];
      int   cnt;

      $display("[TB] start");
      rst_n     = 1'b0;
      out_ready = 1'b1;
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_sum", 32'(sum), 32'd0);
      checkOutput("rst_cout", 32'(c_out), 32'd0);
      checkOutput("rst_ovf", 32'(ovf), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

      // Directed corner sums.
      runSingle("ff_plus_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
`ifdef PIPELINED_ADD_SUB_SATURATE_EN
      runSingle("7f_plus_01", 8'h7F, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
      runSingle("80_minus_01", 8'h80, 8'h01, 1'b1, 8'h80, 1'b1, 1'b1);
`else
      runSingle("7f_plus_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      runSingle("80_minus_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
`endif
      runSingle("05_minus_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);

      // Back-to-back beats, then a 3-cycle consumer stall.
      $display("[TB] stall test");
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b1, 8'(i), 8'(i), 1'b0);
         tick();
      end
      checkOutput("stall_first_valid", 32'(out_valid), 32'd1);
      checkOutput("stall_first_sum", 32'(sum), 32'h02);
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
      out_ready = 1'b0;
      #1;
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("stall_hold_ready", 32'(in_ready), 32'd0);
         checkOutput("stall_hold_sum", 32'(sum), 32'h02);
         checkOutput("stall_hold_valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      for (int i = 2; i <= 4; i++) begin
         tick();
         checkOutput("stall_release_valid", 32'(out_valid), 32'd1);
         checkOutput("stall_release_sum", 32'(sum), 32'(2 * i));
      end
      tick();
      checkOutput("stall_drained", 32'(out_valid), 32'd0);

      // Alternating bubbles: out_valid must echo the input pattern STAGES later.
      $display("[TB] bubble test");
      for (int i = 0; i < 12; i++) begin
         pat[i] = (i < 8) && ((i % 2) == 0);
         applyStimulus(pat[i], 8'($urandom), 8'($urandom), 1'($urandom));
         tick();
         ov[i] = out_valid;
      end
      for (int i = 0; i < 8; i++) begin
         checkOutput("bubble_pattern", 32'(ov[i + STAGES - 1]), 32'(pat[i]));
      end

      // Random traffic with random back-pressure.
      $display("[TB] random traffic");
      for (int i = 0; i < 60; i++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         applyStimulus(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
         tick();
      end
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
      out_ready = 1'b1;
      cnt = 0;
      while (expq.size() != 0 && cnt < 20) begin
         tick();
         cnt++;
      end
      checkOutput("random_drained", 32'(expq.size()), 32'd0);

      // Reset with three beats in flight.
      $display("[TB] mid-flight reset");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
         tick();
      end
      applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      checkOutput("mrst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("mrst_sum", 32'(sum), 32'd0);
      checkOutput("mrst_in_ready", 32'(in_ready), 32'd1);
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (out_valid === 1'b1) cnt++;
      end
      checkOutput("mrst_no_stale", 32'(cnt), 32'd0);
      runSingle("post_rst_10_plus_20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
